// File: rtl/image_window_gen.sv
// image_window_gen: streams every valid 3x3 neighbourhood of a raster image.
// The image is read once, pixel by pixel, from a single-cycle-latency memory.
// The two previous image rows live in two line buffers; two window columns are
// kept in registers, and the third comes straight from the buffers and the
// freshly read pixel.
module image_window_gen #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int PIX_W  = 7,
  parameter int ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_rd_en,
  input  logic [PIX_W-1:0]     mem_data,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic [9*PIX_W-1:0]   win_data,
  output logic [4:0]           win_row,
  output logic [4:0]           win_col,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {IDLE, RD, CAP, OUT, DONE} state_t;

  localparam logic [4:0] COL_LAST = 5'(IMG_W - 1);
  localparam logic [4:0] ROW_LAST = 5'(IMG_H - 1);

  state_t              state;
  logic [4:0]          row;
  logic [4:0]          col;
  logic [ADDR_W-1:0]   pix;

  // Line buffers: lb0 holds the row above the current one, lb1 the row above that.
  logic [PIX_W-1:0]    lb0 [IMG_W];
  logic [PIX_W-1:0]    lb1 [IMG_W];
  logic [PIX_W-1:0]    lb0_q;
  logic [PIX_W-1:0]    lb1_q;

  // Window columns c=0 and c=1 of the next window (index 0 = top row).
  logic [PIX_W-1:0]    c1 [3];
  logic [PIX_W-1:0]    c2 [3];
  logic [PIX_W-1:0]    new_col [3];
  logic [9*PIX_W-1:0]  win_next;

  logic                last_pix;
  logic [4:0]          next_row;
  logic [4:0]          next_col;
  logic [ADDR_W-1:0]   next_pix;

  // Pixel counter advance and end-of-image detection.
  always_comb begin
    last_pix = (row == ROW_LAST) && (col == COL_LAST);
    next_pix = pix + 1'b1;
    next_col = col + 5'd1;
    next_row = row;
    if (col == COL_LAST) begin
      next_col = 5'd0;
      next_row = row + 5'd1;
    end
  end

  // Newest window column: two buffered rows above plus the pixel just read.
  always_comb begin
    new_col[0] = lb1_q;
    new_col[1] = lb0_q;
    new_col[2] = mem_data;
  end

  // Assemble the window: pixel (r,c) sits at PIX_W*(3*r+c).
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
      assign win_next[PIX_W*(3*gi+0) +: PIX_W] = c1[gi];
      assign win_next[PIX_W*(3*gi+1) +: PIX_W] = c2[gi];
      assign win_next[PIX_W*(3*gi+2) +: PIX_W] = new_col[gi];
    end
  endgenerate

  // Line buffers: registered read during RD, write-back of the shifted column during CAP.
  always_ff @(posedge clk) begin
    if (state == RD) begin
      lb0_q <= lb0[col];
      lb1_q <= lb1[col];
    end
    if (state == CAP) begin
      lb1[col] <= lb0_q;
      lb0[col] <= mem_data;
    end
  end

  // Shift the window columns left by one each time a pixel is captured.
  always_ff @(posedge clk) begin
    if (state == CAP) begin
      for (int i = 0; i < 3; i++) begin
        c1[i] <= c2[i];
        c2[i] <= new_col[i];
      end
    end
  end

  // Control FSM with registered memory strobe, window stream and done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row       <= 5'd0;
      col       <= 5'd0;
      pix       <= '0;
      mem_addr  <= '0;
      mem_rd_en <= 1'b0;
      win_valid <= 1'b0;
      win_data  <= '0;
      win_row   <= 5'd0;
      win_col   <= 5'd0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            row       <= 5'd0;
            col       <= 5'd0;
            pix       <= '0;
            mem_addr  <= '0;
            mem_rd_en <= 1'b1;
            state     <= RD;
          end
        end
        RD: begin
          mem_rd_en <= 1'b0;
          mem_addr  <= '0;
          state     <= CAP;
        end
        CAP: begin
          if (row >= 5'd2 && col >= 5'd2) begin
            win_data  <= win_next;
            win_row   <= row - 5'd2;
            win_col   <= col - 5'd2;
            win_valid <= 1'b1;
            state     <= OUT;
          end else if (last_pix) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            row       <= next_row;
            col       <= next_col;
            pix       <= next_pix;
            mem_addr  <= next_pix;
            mem_rd_en <= 1'b1;
            state     <= RD;
          end
        end
        OUT: begin
          if (win_ready) begin
            win_valid <= 1'b0;
            if (last_pix) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              row       <= next_row;
              col       <= next_col;
              pix       <= next_pix;
              mem_addr  <= next_pix;
              mem_rd_en <= 1'b1;
              state     <= RD;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RD) || (state == CAP) || (state == OUT);

endmodule

// File: tb/tb_image_window_gen.sv
// Testbench for image_window_gen: a memory model plus a reference that builds
// each expected window directly from the image array.
module tb_image_window_gen;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int PIX_W = 7;
  localparam int ADDR_W = 10;
  localparam int NWIN_W = IMG_W - 2;
  localparam int NWIN = (IMG_W - 2) * (IMG_H - 2);

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_rd_en;
  logic [PIX_W-1:0]    mem_data;
  logic                win_valid;
  logic                win_ready;
  logic [9*PIX_W-1:0]  win_data;
  logic [4:0]          win_row;
  logic [4:0]          win_col;
  logic                busy;
  logic                done;

  logic [PIX_W-1:0]    img [IMG_W*IMG_H];
  int checks = 0;
  int errors = 0;
  logic [9*PIX_W-1:0]  first_win;
  logic [9*PIX_W-1:0]  last_win;

  image_window_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_data(mem_data),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_row(win_row), .win_col(win_col), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Pixel memory: data appears one cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd_en) mem_data <= img[mem_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9*PIX_W-1:0] ref_win(input int k);
    logic [9*PIX_W-1:0] w;
    int r0, c0;
    r0 = k / NWIN_W;
    c0 = k % NWIN_W;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[PIX_W*(3*i+j) +: PIX_W] = img[(r0+i)*IMG_W + c0 + j];
    return w;
  endfunction

  function automatic logic [9*PIX_W-1:0] pack9(input int v [9]);
    logic [9*PIX_W-1:0] w;
    w = '0;
    for (int i = 0; i < 9; i++) w[PIX_W*i +: PIX_W] = PIX_W'(v[i]);
    return w;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_en"}, 64'(mem_rd_en), 64'd0);
    check({tag, "_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_valid"}, 64'(win_valid), 64'd0);
    check({tag, "_data"}, 64'(win_data), 64'd0);
    check({tag, "_row"}, 64'(win_row), 64'd0);
    check({tag, "_col"}, 64'(win_col), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
  endtask

  // One pass: rand_ready picks 50% win_ready, stall holds off the first window
  // for 10 cycles, abort_at resets mid-OUT at that window index, poke_at pulses
  // start at that cycle, check_cyc verifies the full-throughput cycle count.
  task automatic run_pass(input string name, input bit rand_ready, input bit stall,
                          input int abort_at, input int poke_at, input bit check_cyc);
    int k = 0, done_cnt = 0, rd_idx = 0, busy_cyc = 0, cyc = 0;
    int end_cyc = -1, stall_cnt = 0;
    bit aborted = 0;
    logic [9*PIX_W-1:0] held_data;
    logic [4:0] held_row, held_col;
    @(negedge clk);
    start = 1'b1;
    win_ready = 1'b1;
    while (cyc < 8000 && !aborted && !(end_cyc >= 0 && cyc >= end_cyc + 5)) begin
      @(negedge clk);
      cyc++;
      start = (cyc == poke_at);
      if (busy) busy_cyc++;
      if (mem_rd_en) begin
        check({name, "_rd_addr"}, 64'(mem_addr), 64'(rd_idx));
        rd_idx++;
      end
      if (done) begin
        done_cnt++;
        end_cyc = cyc;
      end
      if (abort_at >= 0 && k == abort_at && win_valid) begin
        win_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs({name, "_abort"});
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          check({name, "_abort_no_rd"}, 64'(mem_rd_en), 64'd0);
          check({name, "_abort_no_done"}, 64'(done), 64'd0);
        end
        aborted = 1;
      end else begin
        win_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
        if (stall && k == 0 && win_valid && stall_cnt < 10) begin
          if (stall_cnt == 0) begin
            held_data = win_data;
            held_row = win_row;
            held_col = win_col;
          end else begin
            check({name, "_stall_data"}, 64'(win_data), 64'(held_data));
            check({name, "_stall_row"}, 64'(win_row), 64'(held_row));
            check({name, "_stall_col"}, 64'(win_col), 64'(held_col));
          end
          check({name, "_stall_no_rd"}, 64'(mem_rd_en), 64'd0);
          stall_cnt++;
          win_ready = 1'b0;
        end
        if (win_valid && win_ready) begin
          check({name, "_win_data"}, 64'(win_data), 64'(ref_win(k)));
          check({name, "_win_row"}, 64'(win_row), 64'(k / NWIN_W));
          check({name, "_win_col"}, 64'(win_col), 64'(k % NWIN_W));
          if (k == 0) first_win = win_data;
          if (k == NWIN - 1) last_win = win_data;
          k++;
        end
      end
    end
    start = 1'b0;
    win_ready = 1'b1;
    if (!aborted) begin
      check({name, "_transfers"}, 64'(k), 64'(NWIN));
      check({name, "_done_pulses"}, 64'(done_cnt), 64'd1);
      check({name, "_reads"}, 64'(rd_idx), 64'(IMG_W*IMG_H));
      if (stall) check({name, "_stall_cycles"}, 64'(stall_cnt), 64'd10);
      if (check_cyc) check({name, "_cycles"}, 64'(busy_cyc), 64'd2244);
    end
    $display("pass %s: %0d windows, %0d done pulses, %0d reads, %0d busy cycles%s",
             name, k, done_cnt, rd_idx, busy_cyc, aborted ? " (aborted)" : "");
  endtask

  initial begin
    int v_first [9] = '{0, 1, 2, 28, 29, 30, 56, 57, 58};
    int v_last  [9] = '{85, 86, 87, 113, 114, 115, 13, 14, 15};
    rst = 1'b1;
    start = 1'b0;
    win_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Ramp image, full-speed consumer: known first/last windows and cycle count.
    for (int i = 0; i < IMG_W*IMG_H; i++) img[i] = PIX_W'(i % 128);
    run_pass("ramp", 0, 0, -1, -1, 1);
    check("ramp_first_window", 64'(first_win), 64'(pack9(v_first)));
    check("ramp_last_window", 64'(last_win), 64'(pack9(v_last)));

    // Back-pressure on the first window.
    for (int i = 0; i < IMG_W*IMG_H; i++) img[i] = PIX_W'($urandom);
    run_pass("stall", 0, 1, -1, -1, 0);

    // Reset in the middle of window 100, then a clean full pass.
    for (int i = 0; i < IMG_W*IMG_H; i++) img[i] = PIX_W'($urandom);
    run_pass("abort", 1, 0, 100, -1, 0);
    run_pass("after_abort", 0, 0, -1, -1, 1);

    // start pulsed while busy is ignored.
    for (int i = 0; i < IMG_W*IMG_H; i++) img[i] = PIX_W'($urandom);
    run_pass("poke", 0, 0, -1, 50, 1);

    // Random win_ready at 50% duty.
    for (int i = 0; i < IMG_W*IMG_H; i++) img[i] = PIX_W'($urandom);
    run_pass("random_ready", 1, 0, -1, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
